// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction cache FSM states and block geometry.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } ins_cache_state_t;

    localparam int BLOCK_W     = 128;
    localparam int WORD_W      = 32;
    localparam int OFFSET_W    = 4;
    localparam int INDEX_W_DEF = 3;
    localparam int TAG_W       = 32 - OFFSET_W - INDEX_W_DEF;

    // Tag width for a cache built with a non-default index width.
    function automatic int tag_w(input int index_w);
        return 32 - OFFSET_W - index_w;
    endfunction

endpackage

// File: rtl/ins_cache_line_array.sv
// Valid/tag/data storage for the instruction cache: async read by index,
// synchronous line install, async clear of valid bits.
module ins_cache_line_array
    import cpu_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [INDEX_W-1:0]               index,
    input  logic                             wr_en,
    input  logic [tag_w(INDEX_W)-1:0]        wr_tag,
    input  logic [BLOCK_W-1:0]               wr_data,
    output logic                             rd_valid,
    output logic [tag_w(INDEX_W)-1:0]        rd_tag,
    output logic [BLOCK_W-1:0]               rd_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_BITS = tag_w(INDEX_W);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [BLOCK_W-1:0]  data_mem [LINES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data need no reset: an invalid line never hits.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[index]  <= wr_tag;
            data_mem[index] <= wr_data;
        end
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tag_mem[index];
    assign rd_data  = data_mem[index];

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: zero-stall hits, one block
// refill from instruction memory per miss.
module ins_cache
    import cpu_pkg::*;
#(
    parameter int INDEX_W = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic [31:0]             address,
    output logic [WORD_W-1:0]       readdata,
    output logic                    busywait,
    output logic                    mem_read,
    output logic [31-OFFSET_W:0]    mem_address,
    input  logic [BLOCK_W-1:0]      mem_readdata,
    input  logic                    mem_busywait
);

    localparam int TAG_BITS = tag_w(INDEX_W);

    ins_cache_state_t    state, next_state;
    logic [TAG_BITS-1:0] tag;
    logic [INDEX_W-1:0]  index;
    logic [1:0]          word;
    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [BLOCK_W-1:0]  line_data;
    logic                hit;
    logic                unused_byte_sel;

    assign tag             = address[31:OFFSET_W+INDEX_W];
    assign index           = address[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign word            = address[3:2];
    assign unused_byte_sel = ^address[1:0];

    ins_cache_line_array #(
        .INDEX_W (INDEX_W)
    ) u_lines (
        .clock    (clock),
        .reset    (reset),
        .index    (index),
        .wr_en    (state == UPDATE),
        .wr_tag   (tag),
        .wr_data  (mem_readdata),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign hit      = line_valid && (line_tag == tag);
    assign readdata = line_data[{word, 5'b0} +: WORD_W];
    assign busywait = read && (!hit || state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (read && !hit) next_state = MEM_READ;
            MEM_READ: if (!mem_busywait) next_state = UPDATE;
            UPDATE:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Memory-side outputs are registered from the next state so the request
    // drops on the very edge that enters UPDATE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            state       <= next_state;
            mem_read    <= (next_state == MEM_READ);
            mem_address <= (next_state == MEM_READ) ? address[31:OFFSET_W] : '0;
        end
    end

endmodule

// File: doc/ins_cache.md
# ins_cache

Direct-mapped, read-only instruction cache between the IF stage (PC-driven fetch) and the 128-bit-block instruction memory. It returns one 32-bit instruction per hit with zero stall cycles. On a miss it stalls the pipeline via `busywait`, fetches the full 16-byte block from instruction memory over the read/busywait handshake, installs it, and then serves the hit.

## Interface
Parameters:
- `INDEX_W`, default 3: index bits; the cache has 2^INDEX_W lines (8 by default).
- `OFFSET_W`, fixed 4: byte offset within a 128-bit block; not overridable.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `read`, in, 1: fetch request from IF; held high while `busywait`=1.
- `address`, in, 32: byte PC. Bits [1:0] are ignored. Must be held stable while `busywait`=1.
- `readdata`, out, 32: selected instruction word.
- `busywait`, out, 1: stall request to the pipeline.
- `mem_read`, out, 1: block read request to instruction memory.
- `mem_address`, out, 28: block address, equal to `address[31:4]`.
- `mem_readdata`, in, 128: fetched block; byte 0 is in [7:0].
- `mem_busywait`, in, 1: memory busy; follows `mem_read` high and drops when data is valid.

## Operation
- Address split: tag = `address[31:4+INDEX_W]` (25 bits by default), index = `address[3+INDEX_W:4]`, word = `address[3:2]`.
- Per line: valid bit, tag, and a 128-bit data word.
- hit = `valid[index]` && (`tag[index]` == tag).
- `readdata`:
  - Combinational: `data[index][32*word +: 32]`.
  - Meaningful only when `read`=1, hit is true and the FSM is in IDLE.
  - Otherwise it holds the same combinational value; the value is don't-care for the CPU.
- `busywait` = `read` && (!hit || state != IDLE). It is combinational.
- FSM states are IDLE, MEM_READ and UPDATE.
  - IDLE: if `read`=1 and not hit, go to MEM_READ. Otherwise stay in IDLE.
  - MEM_READ:
    - `mem_read`=1.
    - `mem_address` = {tag, index}.
    - Go to UPDATE on the first rising edge where `mem_busywait` is sampled 0. Otherwise stay.
  - UPDATE:
    - `mem_read`=0.
    - On this edge, write the line: data = `mem_readdata`, tag = tag, valid = 1.
    - Go to IDLE.
- After UPDATE the same address hits in IDLE, and `busywait` falls combinationally.
- Outputs are Moore outputs; `mem_read` and `mem_address` are registered from the next state.
- No write path and no coherence with data memory: instruction memory is read-only.
- Reset (asynchronous, any state, including mid-refill):
  - All valid bits clear.
  - State goes to IDLE.
  - `mem_read`=0 and `mem_address`=0.
  - `busywait` = `read` (forced miss). With `read`=0 after reset, `busywait`=0 and `readdata` is don't-care.
  - A refill aborted by reset installs nothing.
  - A late `mem_readdata` after reset is ignored.
- `read`=0 in IDLE: no state change and `busywait`=0.

## Timing
- Hit: 0 stall cycles; data is valid in the same cycle as the address.
- Miss, measured in cycles from the rising edge that leaves IDLE:
  - MEM_READ lasts N cycles, where N is the number of edges until `mem_busywait` is sampled low. With a 40 ns per-byte memory this is set by memory latency, not by this block.
  - UPDATE lasts 1 cycle.
  - `busywait` then falls in the IDLE cycle.
  - Total miss penalty is N+2 edges.
- `mem_read` deasserts on the edge entering UPDATE, so instruction memory sees exactly one request per miss.
- The data and tag arrays are written only on the UPDATE edge. Reads are asynchronous.

## Structure
- The shared package `cpu_pkg` holds:
  - The `ins_cache_state_t` enum (IDLE, MEM_READ, UPDATE).
  - The constants `BLOCK_W`=128, `WORD_W`=32 and `OFFSET_W`=4.
  - Derived `TAG_W` = 32-OFFSET_W-INDEX_W.
- One natural sub-module, `ins_cache_line_array`:
  - Holds the valid, tag and data arrays.
  - Asynchronous read by index.
  - Synchronous write enable.
  - Asynchronous clear of the valid bits.
- The FSM, hit compare and word mux stay in the top level.

## Test plan
- Cold miss:
  - Stimulus: reset, then `read`=1, `address`=0x0000_0004.
  - Required response:
    - `busywait`=1 immediately.
    - `mem_read` is asserted with `mem_address`=0x000_0000.
    - After memory returns a block with word1=0x0050_0093, `busywait` falls and `readdata`=0x0050_0093.
- Spatial hit:
  - Stimulus: after the cold miss, `address`=0x0000_000C.
  - Required response: `busywait`=0 in the same cycle, `readdata` = word3 of the block, and `mem_read` stays 0.
- Conflict miss:
  - Stimulus: `address`=0x0000_0080, which has the same index 0 and a different tag.
  - Required response:
    - A miss occurs and `mem_address`=0x000_0008.
    - After refill, `address`=0x0000_0000 misses again and the block is refetched.
- Long memory latency:
  - Stimulus: `mem_busywait` is held high for 10 cycles.
  - Required response: `busywait` stays 1 throughout and `mem_read` stays 1 throughout. Exactly one UPDATE follows.
- Reset mid-refill:
  - Stimulus: assert `reset`=0 while in MEM_READ.
  - Required response:
    - `mem_read` goes to 0 immediately.
    - After release, the previously valid address misses.
- Idle:
  - Stimulus: `read`=0 with an arbitrary `address`.
  - Required response: `busywait`=0, `mem_read`=0, and no state change.
